// File: rtl/math_adder_carry_save_accum.sv
// -----------------------------------------------------------------------------
// math_adder_carry_save_accum
//
// Purpose:
//   Streaming multi-operand accumulator. A run is opened with i_start, which
//   fixes how many unsigned N-bit operands will be summed. Each accepted
//   operand is folded into a redundant (sum, carry) pair by one 3:2
//   compressor, so the per-operand path has no carry chain. When the last
//   operand has been taken, a single carry-propagate add in RESOLVE produces
//   the binary result, which is then held on o_result until the downstream
//   side takes it.
//
// Handshakes (both channels use the same rule):
//   A transfer happens on the rising edge where valid and ready are both
//   high. The producer holds valid and data stable until that edge; ready may
//   change freely and does not depend combinationally on valid.
//     operand channel: i_valid / o_ready / i_data    (into this block)
//     result channel : o_valid / i_ready / o_result  (out of this block)
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        asynchronous reset, active-high
//   i_start      open a run (only looked at while idle)
//   i_num_terms  operand count for the run, captured with i_start
//   i_valid      operand valid
//   o_ready      operand ready (registered)
//   i_data       operand, zero-extended to ACC_W
//   o_valid      result valid
//   i_ready      result ready from downstream
//   o_result     final sum, ACC_W bits
//   o_busy       high whenever a run is in progress
//   o_err        sticky: last accepted start asked for more than MAX_TERMS
//   o_dbg_state  current FSM state (IDLE=0, ACCUM=1, RESOLVE=2, DONE=3)
// -----------------------------------------------------------------------------
module math_adder_carry_save_accum #(
    parameter int N         = 16,
    parameter int MAX_TERMS = 8,
    parameter int CW        = $clog2(MAX_TERMS + 1),
    parameter int ACC_W     = N + $clog2(MAX_TERMS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CW-1:0]    i_num_terms,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [ACC_W-1:0] o_result,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TERMS);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [ACC_W-1:0]   sum_q,    sum_d;
    logic [ACC_W-1:0]   carry_q,  carry_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               ready_q,  ready_d;
    logic               valid_q,  valid_d;
    logic               err_q,    err_d;

    // ---------------------------------------------------------------------
    // 3:2 compressor
    // The operand is zero-extended. The majority term is shifted up one
    // place to form the new carry word; its top bit falls off. Because
    // ACC_W is wide enough for MAX_TERMS full-scale operands, the true
    // running sum never reaches 2^ACC_W, so the discarded bit is always 0
    // and sum+carry stays exact.
    // ---------------------------------------------------------------------
    logic [ACC_W-1:0] data_ext;
    logic [ACC_W-1:0] csa_sum;
    logic [ACC_W-2:0] csa_maj;
    logic [ACC_W-1:0] csa_carry;

    always_comb begin
        data_ext  = {{(ACC_W - N){1'b0}}, i_data};
        csa_sum   = sum_q ^ carry_q ^ data_ext;
        csa_maj   = (sum_q[ACC_W-2:0]   & carry_q[ACC_W-2:0])
                  | (sum_q[ACC_W-2:0]   & data_ext[ACC_W-2:0])
                  | (carry_q[ACC_W-2:0] & data_ext[ACC_W-2:0]);
        csa_carry = {csa_maj, 1'b0};
    end

    // Operand transfer. ready_q is only ever high in ACCUM.
    logic accept;
    assign accept = i_valid & ready_q;

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    // Over-range requests are clamped and flagged; the run
                    // still proceeds with MAX_TERMS operands.
                    if (i_num_terms > MAX_CNT) begin
                        cnt_d = MAX_CNT;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = i_num_terms;
                        err_d = 1'b0;
                    end
                    // An empty run goes straight to the final add (of 0+0).
                    if (i_num_terms == '0) begin
                        state_d = ST_RESOLVE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end

            ST_ACCUM: begin
                if (accept) begin
                    sum_d   = csa_sum;
                    carry_d = csa_carry;
                    cnt_d   = cnt_q - ONE_CNT;
                    if (cnt_q == ONE_CNT) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end

            ST_RESOLVE: begin
                // The only carry-propagate adder in the block.
                result_d = sum_q + carry_q;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                if (valid_q && i_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags follow the state being entered, so o_ready falls on
        // the same edge that takes the last operand and o_valid rises on the
        // edge that loads o_result.
        ready_d = (state_d == ST_ACCUM);
        valid_d = (state_d == ST_DONE);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            sum_q    <= '0;
            carry_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_err       = err_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_math_adder_carry_save_accum.sv
module tb_math_adder_carry_save_accum;

  localparam int N         = 8;
  localparam int MAX_TERMS = 8;
  localparam int CW        = $clog2(MAX_TERMS + 1);
  localparam int ACC_W     = N + $clog2(MAX_TERMS);

  // ---------------- clock / reset / signals ----------------
  logic             clk;
  logic             rst;
  logic             i_start;
  logic [CW-1:0]    i_num_terms;
  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     i_data;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_result;
  logic             o_busy;
  logic             o_err;
  logic [1:0]       dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  math_adder_carry_save_accum #(
    .N(N),
    .MAX_TERMS(MAX_TERMS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(i_start),
    .i_num_terms(i_num_terms),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data(i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_result(o_result),
    .o_busy(o_busy),
    .o_err(o_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0]     offered[$];   // operands presented for the current run
  logic [N-1:0]     ops_q[$];     // operands still waiting to be driven
  logic [N-1:0]     acc_q[$];     // operands seen accepted
  logic [ACC_W-1:0] exp_q[$];     // expected results

  // Reference: plain integer sum of the first min(num, MAX_TERMS) operands.
  function automatic logic [ACC_W-1:0] model_sum(input int num);
    int unsigned s;
    int k;
    s = 0;
    k = (num > MAX_TERMS) ? MAX_TERMS : num;
    for (int i = 0; i < k; i++) s += offered[i];
    return ACC_W'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input int num);
    @(negedge clk);
    i_start     = 1'b1;
    i_num_terms = CW'(num);
    @(negedge clk);
    i_start     = 1'b0;
  endtask

  // Presents operands from ops_q with random gaps until `want` accepts.
  task automatic drive_ops(input int want, input int gap_pct, input int budget,
                           output bit timed_out);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    timed_out = 1'b0;
    while (n < want) begin
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      if (ops_q.size() > 0 && $urandom_range(99, 0) >= gap_pct) begin
        i_valid = 1'b1;
        i_data  = ops_q[0];
      end else begin
        i_valid = 1'b0;
        i_data  = N'($urandom);
      end
      if (i_valid && o_ready) begin
        acc_q.push_back(i_data);
        void'(ops_q.pop_front());
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit timed_out);
    int cyc;
    cyc = 0;
    timed_out = 1'b0;
    while (o_valid !== 1'b1) begin
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
  endtask

  task automatic new_run(input int cnt, input bit rand_data);
    offered.delete();
    acc_q.delete();
    for (int i = 0; i < cnt; i++)
      offered.push_back(rand_data ? N'($urandom) : N'(i + 1));
    ops_q = offered;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    i_start = 1'b0; i_num_terms = '0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_ready, o_valid, o_busy, o_err} !== 4'b0 || o_result !== '0)
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b err=%b result=%h, required all 0",
               o_ready, o_valid, o_busy, o_err, o_result);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b0)
      $display("FAIL reset_release_idle: busy=%b ready=%b, required 0 0", o_busy, o_ready);
    else n_pass++;
  endtask

  task automatic test_four_ff();
    bit to;
    offered.delete(); acc_q.delete();
    repeat (4) offered.push_back(8'hFF);
    ops_q = offered;
    exp_q.push_back(model_sum(4));
    do_start(4);
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b1)
      $display("FAIL ff_ready_after_start: ready=%b busy=%b, required 1 1", o_ready, o_busy);
    else n_pass++;
    drive_ops(4, 0, 20, to);
    n_checks++;
    if (to) $display("FAIL ff_accepts: timed out with %0d accepts, required 4", acc_q.size());
    else n_pass++;
    // Now one cycle after the 4th accepting edge: ready gone, result not yet valid.
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL ff_after_last_accept: ready=%b valid=%b, required 0 0", o_ready, o_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1)
      $display("FAIL ff_latency: valid=%b two edges after last accept, required 1", o_valid);
    else n_pass++;
    n_checks++;
    if (o_result !== 11'h3FC || o_result !== exp_q[0])
      $display("FAIL ff_result: got %h, required 3fc (model %h)", o_result, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    release_result();
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL ff_handshake_done: valid=%b busy=%b, required 0 0", o_valid, o_busy);
    else n_pass++;
  endtask

  task automatic test_zero_terms();
    bit to;
    int ready_seen;
    int cyc;
    ready_seen = 0;
    offered.delete();
    exp_q.push_back(model_sum(0));
    do_start(0);
    cyc = 0;
    to = 1'b0;
    while (o_valid !== 1'b1) begin
      if (o_ready === 1'b1) ready_seen++;
      if (cyc >= 10) begin to = 1'b1; break; end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (to || ready_seen != 0)
      $display("FAIL zero_terms_flow: timeout=%0d ready_cycles=%0d, required 0 0", to, ready_seen);
    else n_pass++;
    n_checks++;
    if (o_result !== exp_q[0])
      $display("FAIL zero_terms_result: got %h, required %h", o_result, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    release_result();
  endtask

  task automatic test_stall();
    bit to;
    new_run(8, 1'b0);
    exp_q.push_back(model_sum(8));
    do_start(8);
    drive_ops(8, 40, 200, to);
    n_checks++;
    if (to) $display("FAIL stall_accepts: timed out with %0d accepts, required 8", acc_q.size());
    else n_pass++;
    wait_valid(10, to);
    n_checks++;
    if (to) $display("FAIL stall_valid: o_valid never rose, required 1");
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (o_valid !== 1'b1 || o_result !== exp_q[0] || o_result !== 11'd36)
        $display("FAIL stall_hold_%0d: valid=%b result=%0d, required 1 %0d", c, o_valid, o_result, exp_q[0]);
      else n_pass++;
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    release_result();
  endtask

  task automatic test_over_max();
    bit to;
    new_run(12, 1'b1);
    exp_q.push_back(model_sum(12));
    do_start(12);
    n_checks++;
    if (o_err !== 1'b1) $display("FAIL over_err_set: err=%b, required 1", o_err);
    else n_pass++;
    drive_ops(8, 0, 40, to);
    // Keep offering the 9th operand; nothing more may be taken.
    i_valid = 1'b1;
    i_data  = ops_q[0];
    n_checks++;
    if (to || o_ready !== 1'b0)
      $display("FAIL over_accept_count: timeout=%0d ready=%b after 8 accepts, required 0 0", to, o_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== exp_q[0])
      $display("FAIL over_result: valid=%b result=%h, required 1 %h", o_valid, o_result, exp_q[0]);
    else n_pass++;
    i_valid = 1'b0;
    void'(exp_q.pop_front());
    release_result();
    n_checks++;
    if (o_err !== 1'b1) $display("FAIL over_err_sticky: err=%b, required 1", o_err);
    else n_pass++;
    new_run(3, 1'b1);
    exp_q.push_back(model_sum(3));
    do_start(3);
    n_checks++;
    if (o_err !== 1'b0) $display("FAIL over_err_clear: err=%b, required 0", o_err);
    else n_pass++;
    drive_ops(3, 20, 60, to);
    wait_valid(10, to);
    n_checks++;
    if (to || o_result !== exp_q[0])
      $display("FAIL over_followup_result: timeout=%0d result=%h, required 0 %h", to, o_result, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    release_result();
  endtask

  task automatic test_reset_mid();
    bit to;
    int valid_seen;
    new_run(4, 1'b1);
    do_start(4);
    drive_ops(2, 0, 20, to);
    rst = 1'b1;
    #2;
    n_checks++;
    if ({o_ready, o_valid, o_busy, o_err} !== 4'b0 || o_result !== '0)
      $display("FAIL midreset_outputs: ready=%b valid=%b busy=%b err=%b result=%h, required all 0",
               o_ready, o_valid, o_busy, o_err, o_result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    valid_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid === 1'b1 || o_busy === 1'b1) valid_seen++;
    end
    n_checks++;
    if (valid_seen != 0)
      $display("FAIL midreset_quiet: %0d cycles with valid/busy after reset, required 0", valid_seen);
    else n_pass++;
    offered.delete(); acc_q.delete();
    offered.push_back(8'd3);
    offered.push_back(8'd5);
    ops_q = offered;
    exp_q.push_back(model_sum(2));
    do_start(2);
    drive_ops(2, 0, 20, to);
    wait_valid(10, to);
    n_checks++;
    if (to || o_result !== 11'd8 || o_result !== exp_q[0])
      $display("FAIL midreset_rerun: timeout=%0d result=%0d, required 0 8", to, o_result);
    else n_pass++;
    void'(exp_q.pop_front());
    release_result();
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [ACC_W-1:0] held;
    new_run(4, 1'b1);
    exp_q.push_back(model_sum(4));
    do_start(4);
    drive_ops(2, 0, 20, to);
    i_start = 1'b1;
    i_num_terms = CW'(1);
    repeat (2) @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b1)
      $display("FAIL ignore_start_accum: ready=%b busy=%b, required 1 1", o_ready, o_busy);
    else n_pass++;
    drive_ops(2, 0, 20, to);
    wait_valid(10, to);
    n_checks++;
    if (to || o_result !== exp_q[0])
      $display("FAIL ignore_start_result: timeout=%0d result=%h, required 0 %h", to, o_result, exp_q[0]);
    else n_pass++;
    held = exp_q.pop_front();
    i_start = 1'b1;
    i_num_terms = CW'(0);
    repeat (2) @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_result !== held || o_ready !== 1'b0)
      $display("FAIL ignore_start_done: valid=%b result=%h ready=%b, required 1 %h 0",
               o_valid, o_result, o_ready, held);
    else n_pass++;
    release_result();
  endtask

  task automatic test_back_to_back_random();
    bit to;
    int num;
    for (int r = 0; r < 8; r++) begin
      num = $urandom_range(10, 0);
      new_run(num, 1'b1);
      exp_q.push_back(model_sum(num));
      do_start(num);
      n_checks++;
      if (o_err !== (num > MAX_TERMS))
        $display("FAIL rand_err_%0d: err=%b num=%0d, required %0d", r, o_err, num, num > MAX_TERMS);
      else n_pass++;
      drive_ops((num > MAX_TERMS) ? MAX_TERMS : num, 30, 200, to);
      wait_valid(10, to);
      n_checks++;
      if (to || o_result !== exp_q[0])
        $display("FAIL rand_result_%0d: timeout=%0d num=%0d result=%h, required 0 %h",
                 r, to, num, o_result, exp_q[0]);
      else n_pass++;
      void'(exp_q.pop_front());
      repeat ($urandom_range(3, 0)) @(negedge clk);
      release_result();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_four_ff();
    test_zero_terms();
    test_stall();
    test_over_max();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
